// File: rtl/predictor_scoreboard.sv
// Scores the two pattern predictors (y, z) against the observed bit x over a
// window of WINDOW valid samples. Optional macro SB_STREAK_EN adds longest-hit-run outputs.
module predictor_scoreboard #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sample_cnt,
    output logic [WIDTH-1:0] y_hits,
    output logic [WIDTH-1:0] z_hits,
    output logic [1:0]       winner,
`ifdef SB_STREAK_EN
    output logic [WIDTH-1:0] y_streak,
    output logic [WIDTH-1:0] z_streak,
`endif
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WINDOW - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [1:0] WIN_TIE = 2'b00;
    localparam logic [1:0] WIN_Y   = 2'b01;
    localparam logic [1:0] WIN_Z   = 2'b10;

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sample_cnt_q, sample_cnt_d;
    logic [WIDTH-1:0] y_hits_q, y_hits_d;
    logic [WIDTH-1:0] z_hits_q, z_hits_d;
    logic [1:0]       winner_q, winner_d;
    logic             y_hit, z_hit;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Next values assuming the current sample is accepted; only used in RUN with valid.
    always_comb begin
        y_hit        = (y == x);
        z_hit        = (z == x);
        sample_cnt_d = sample_cnt_q + CNT_ONE;
        y_hits_d     = y_hit ? sat_inc(y_hits_q) : y_hits_q;
        z_hits_d     = z_hit ? sat_inc(z_hits_q) : z_hits_q;
        winner_d     = WIN_TIE;
        if (y_hits_d > z_hits_d) begin
            winner_d = WIN_Y;
        end else if (z_hits_d > y_hits_d) begin
            winner_d = WIN_Z;
        end
    end

`ifdef SB_STREAK_EN
    logic [WIDTH-1:0] y_run_q, y_run_d, y_run_inc;
    logic [WIDTH-1:0] z_run_q, z_run_d, z_run_inc;
    logic [WIDTH-1:0] y_streak_q, y_streak_d;
    logic [WIDTH-1:0] z_streak_q, z_streak_d;

    // A hit extends the run; the streak is max(streak, run+1), both saturating.
    always_comb begin
        y_run_inc  = sat_inc(y_run_q);
        z_run_inc  = sat_inc(z_run_q);
        y_run_d    = y_hit ? y_run_inc : '0;
        z_run_d    = z_hit ? z_run_inc : '0;
        y_streak_d = y_streak_q;
        z_streak_d = z_streak_q;
        if (y_hit && (y_run_inc > y_streak_q)) begin
            y_streak_d = y_run_inc;
        end
        if (z_hit && (z_run_inc > z_streak_q)) begin
            z_streak_d = z_run_inc;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sample_cnt_q <= '0;
            y_hits_q     <= '0;
            z_hits_q     <= '0;
            winner_q     <= WIN_TIE;
`ifdef SB_STREAK_EN
            y_run_q      <= '0;
            z_run_q      <= '0;
            y_streak_q   <= '0;
            z_streak_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    // Results from the last window stay visible until a new start.
                    if (start) begin
                        state_q      <= ST_RUN;
                        busy_q       <= 1'b1;
                        sample_cnt_q <= '0;
                        y_hits_q     <= '0;
                        z_hits_q     <= '0;
                        winner_q     <= WIN_TIE;
`ifdef SB_STREAK_EN
                        y_run_q      <= '0;
                        z_run_q      <= '0;
                        y_streak_q   <= '0;
                        z_streak_q   <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (valid) begin
                        sample_cnt_q <= sample_cnt_d;
                        y_hits_q     <= y_hits_d;
                        z_hits_q     <= z_hits_d;
`ifdef SB_STREAK_EN
                        y_run_q      <= y_run_d;
                        z_run_q      <= z_run_d;
                        y_streak_q   <= y_streak_d;
                        z_streak_q   <= z_streak_d;
`endif
                        if (sample_cnt_q == CNT_LAST) begin
                            state_q  <= ST_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            winner_q <= winner_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_cnt = sample_cnt_q;
    assign y_hits     = y_hits_q;
    assign z_hits     = z_hits_q;
    assign winner     = winner_q;
    assign state_o    = state_q;
`ifdef SB_STREAK_EN
    assign y_streak   = y_streak_q;
    assign z_streak   = z_streak_q;
`endif

endmodule

// File: tb/tb_predictor_scoreboard.sv
// Bench for predictor_scoreboard: directed windows, expected results queued per window,
// a monitor compares them whenever done pulses.
module tb_predictor_scoreboard;

    localparam int WIDTH  = 8;
    localparam int WINDOW = 16;
    localparam int EW     = 3 * WIDTH + 2;

    logic             clk;
    logic             reset;
    logic             start, valid, x, y, z;
    logic             busy, done;
    logic [WIDTH-1:0] sample_cnt, y_hits, z_hits;
    logic [1:0]       winner;
    logic [1:0]       state_o;
`ifdef SB_STREAK_EN
    logic [WIDTH-1:0] y_streak, z_streak;
`endif

    logic [EW-1:0] exp_q[$];
    int            tests_run;
    int            tests_failed;
    int            done_cnt;

    predictor_scoreboard #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .valid      (valid),
        .x          (x),
        .y          (y),
        .z          (z),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt),
        .y_hits     (y_hits),
        .z_hits     (z_hits),
        .winner     (winner),
`ifdef SB_STREAK_EN
        .y_streak   (y_streak),
        .z_streak   (z_streak),
`endif
        .state_o    (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver: one clock cycle of inputs, returns 1 time unit after the capturing edge
    task automatic cyc(input logic s, input logic v, input logic xx, input logic yy, input logic zz);
        start = s;
        valid = v;
        x     = xx;
        y     = yy;
        z     = zz;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [EW-1:0] pack(input int cnt, input int yh, input int zh, input logic [1:0] w);
        return {WIDTH'(cnt), WIDTH'(yh), WIDTH'(zh), w};
    endfunction

    // scoreboard monitor
    task automatic monitor();
        logic [EW-1:0] exp_v;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("win_sample_cnt", 32'(sample_cnt), 32'(exp_v[EW-1 -: WIDTH]));
                    chk("win_y_hits",     32'(y_hits),     32'(exp_v[2*WIDTH+1 -: WIDTH]));
                    chk("win_z_hits",     32'(z_hits),     32'(exp_v[WIDTH+1 -: WIDTH]));
                    chk("win_winner",     32'(winner),     32'(exp_v[1:0]));
                    chk("win_busy_low",   32'(busy),       32'd0);
                end
            end
        end
    endtask

    logic [15:0] y_pat;
    logic        xb;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        done_cnt     = 0;
        start = 1'b0; valid = 1'b0; x = 1'b0; y = 1'b0; z = 1'b0;
        reset = 1'b1;
        fork
            monitor();
        join_none
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_done",   32'(done),       32'd0);
        chk("rst_cnt",    32'(sample_cnt), 32'd0);
        chk("rst_winner", 32'(winner),     32'd0);
        reset = 1'b0;
        idle(2);

        // abort mid-window with reset: no done, everything cleared
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid_busy", 32'(busy),       32'd1);
        chk("mid_cnt",  32'(sample_cnt), 32'd5);
        chk("mid_yh",   32'(y_hits),     32'd5);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy",   32'(busy),       32'd0);
        chk("abort_cnt",    32'(sample_cnt), 32'd0);
        chk("abort_yh",     32'(y_hits),     32'd0);
        chk("abort_zh",     32'(z_hits),     32'd0);
        chk("abort_winner", 32'(winner),     32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(3);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // all-Y window; valid with the start cycle is not counted
        exp_q.push_back(pack(16, 16, 0, 2'b01));
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("w1_busy_after_start", 32'(busy),       32'd1);
        chk("w1_cnt_after_start",  32'(sample_cnt), 32'd0);
        for (int i = 0; i < WINDOW - 1; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("w1_no_early_done", 32'(done),       32'd0);
        chk("w1_cnt15",         32'(sample_cnt), 32'd15);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("w1_done_latency", 32'(done), 32'd1);
        chk("w1_winner",       32'(winner), 32'd1);
        idle(1);
        chk("w1_done_one_cycle", 32'(done),     32'd0);
        chk("w1_single_done",    32'(done_cnt), 32'd1);

        // alternating x, y always wrong, z always right, three idle gaps
        exp_q.push_back(pack(16, 0, 16, 2'b10));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WINDOW; i++) begin
            if (i == 4 || i == 9 || i == 13) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            xb = (i % 2 == 0);
            if (i == WINDOW - 1) chk("w2_no_early_done", 32'(done), 32'd0);
            cyc(1'b0, 1'b1, xb, ~xb, xb);
        end
        chk("w2_done", 32'(done), 32'd1);
        idle(2);
        chk("w2_single_done", 32'(done_cnt), 32'd2);

        // y right on first half, z right on second half: tie, then held
        exp_q.push_back(pack(16, 8, 8, 2'b00));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WINDOW; i++) begin
            xb = i[0];
            cyc(1'b0, 1'b1, xb, (i < 8) ? xb : ~xb, (i < 8) ? ~xb : xb);
        end
        chk("w3_done", 32'(done), 32'd1);
        idle(10);
        chk("w3_hold_cnt",    32'(sample_cnt), 32'd16);
        chk("w3_hold_yh",     32'(y_hits),     32'd8);
        chk("w3_hold_zh",     32'(z_hits),     32'd8);
        chk("w3_hold_winner", 32'(winner),     32'd0);
        chk("w3_hold_busy",   32'(busy),       32'd0);

        // start held during RUN and in the DONE cycle must be ignored
        exp_q.push_back(pack(16, 0, 16, 2'b10));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WINDOW; i++) cyc((i >= 3 && i <= 7) || i == WINDOW - 1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("w4_done", 32'(done), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("w4_start_in_done_busy", 32'(busy),       32'd0);
        chk("w4_start_in_done_done", 32'(done),       32'd0);
        chk("w4_held_cnt",           32'(sample_cnt), 32'd16);
        chk("w4_held_zh",            32'(z_hits),     32'd16);
        chk("w4_single_done",        32'(done_cnt),   32'd4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_busy",   32'(busy),       32'd1);
        chk("restart_cnt",    32'(sample_cnt), 32'd0);
        chk("restart_yh",     32'(y_hits),     32'd0);
        chk("restart_zh",     32'(z_hits),     32'd0);
        chk("restart_winner", 32'(winner),     32'd0);

        // y hit pattern H H H M H H H H H M H H M H H H (13 hits, best run 5), z always right
        y_pat = 16'b1110110111110111;
        exp_q.push_back(pack(16, 13, 16, 2'b10));
        for (int i = 0; i < WINDOW; i++) begin
            if (i == 6) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            xb = ~i[0];
            cyc(1'b0, 1'b1, xb, y_pat[i] ? xb : ~xb, xb);
        end
        chk("w5_done", 32'(done), 32'd1);
`ifdef SB_STREAK_EN
        chk("w5_y_streak", 32'(y_streak), 32'd5);
        chk("w5_z_streak", 32'(z_streak), 32'd16);
        idle(3);
        chk("w5_y_streak_held", 32'(y_streak), 32'd5);
`else
        idle(3);
`endif
        chk("total_done_pulses", 32'(done_cnt),      32'd5);
        chk("exp_q_drained",     32'(exp_q.size()),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
